lm32_ram: RTL and testbench

Generic single-clock, simple dual-port RAM with one synchronous-read port and one synchronous-write port. It is the storage primitive under the LM32 caches and TLBs; for example, the data TLB stores `{pfn, tag, valid}` entries in it. Read data is presented from a registered read address, so a lookup issued in one cycle is valid in the next.

---
 rtl/lm32_ram.sv | 38 +++
 tb/tb_lm32_ram.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/lm32_ram.sv
// rtl/lm32_ram.sv - simple dual-port RAM, registered read address, synchronous write
module lm32_ram #(
   parameter int data_width    = 1,
   parameter int address_width = 1
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic [address_width-1:0] read_address,
   input  logic                     enable_read,
   input  logic [address_width-1:0] write_address,
   input  logic                     enable_write,
   input  logic                     write_enable,
   input  logic [data_width-1:0]    write_data,
   output logic [data_width-1:0]    read_data
);

   localparam int depth = 2 ** address_width;

   logic [data_width-1:0]    mem [0:depth-1];
   logic [address_width-1:0] ra;

   // Storage has no reset so it infers as RAM; writes are held off during reset.
   always_ff @(posedge clk_i) begin
      if (rst_n_i && enable_write && write_enable)
         mem[write_address] <= write_data;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)
         ra <= '0;
      else if (enable_read)
         ra <= read_address;
   end

   // Reading through the registered address makes a same-edge write visible (write-first).
   assign read_data = mem[ra];

endmodule

// File: tb/tb_lm32_ram.sv
// tb/tb_lm32_ram.sv - self-checking bench for lm32_ram (8x16 and 44x1024 shapes)
module tb_lm32_ram;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;

   logic [3:0] read_address = '0;
   logic       enable_read = 1'b0;
   logic [3:0] write_address = '0;
   logic       enable_write = 1'b0;
   logic       write_enable = 1'b0;
   logic [7:0] write_data = '0;
   logic [7:0] read_data;

   logic [9:0]  w_read_address = '0;
   logic        w_enable_read = 1'b0;
   logic [9:0]  w_write_address = '0;
   logic        w_enable_write = 1'b0;
   logic        w_write_enable = 1'b0;
   logic [43:0] w_write_data = '0;
   logic [43:0] w_read_data;

   int checks = 0;
   int errors = 0;

   logic [63:0] sb_q [$];

   typedef struct {
      logic       ren;
      logic [3:0] raddr;
      logic       ew;
      logic       we;
      logic [3:0] waddr;
      logic [7:0] wdata;
      logic       check;
      logic [7:0] exp;
      string      name;
   } vec_t;

   vec_t vecs [13];

   always #5 clk = ~clk;

   lm32_ram #(.data_width(8), .address_width(4)) dut (
      .clk_i        (clk),
      .rst_n_i      (rst_n),
      .read_address (read_address),
      .enable_read  (enable_read),
      .write_address(write_address),
      .enable_write (enable_write),
      .write_enable (write_enable),
      .write_data   (write_data),
      .read_data    (read_data)
   );

   lm32_ram #(.data_width(44), .address_width(10)) dut_wide (
      .clk_i        (clk),
      .rst_n_i      (rst_n),
      .read_address (w_read_address),
      .enable_read  (w_enable_read),
      .write_address(w_write_address),
      .enable_write (w_enable_write),
      .write_enable (w_write_enable),
      .write_data   (w_write_data),
      .read_data    (w_read_data)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic ren, input logic [3:0] ra, input logic ew,
                        input logic we, input logic [3:0] wa, input logic [7:0] wd);
      enable_read   = ren;
      read_address  = ra;
      enable_write  = ew;
      write_enable  = we;
      write_address = wa;
      write_data    = wd;
   endtask

   task automatic set_vec(input int i, input logic ren, input logic [3:0] ra,
                          input logic ew, input logic we, input logic [3:0] wa,
                          input logic [7:0] wd, input logic c, input logic [7:0] e,
                          input string n);
      vecs[i].ren = ren; vecs[i].raddr = ra; vecs[i].ew = ew; vecs[i].we = we;
      vecs[i].waddr = wa; vecs[i].wdata = wd; vecs[i].check = c; vecs[i].exp = e;
      vecs[i].name = n;
   endtask

   initial begin
      set_vec(0,  1'b0, 4'd0,  1'b1, 1'b1, 4'd3, 8'h11, 1'b0, 8'h00, "wr3");
      set_vec(1,  1'b0, 4'd0,  1'b1, 1'b1, 4'd4, 8'h22, 1'b0, 8'h00, "wr4");
      set_vec(2,  1'b1, 4'd3,  1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 8'h11, "read3");
      set_vec(3,  1'b1, 4'd4,  1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 8'h22, "read4");
      set_vec(4,  1'b1, 4'd3,  1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 8'h11, "latch3");
      set_vec(5,  1'b0, 4'd9,  1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 8'h11, "hold_a9");
      set_vec(6,  1'b0, 4'd4,  1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 8'h11, "hold_a4");
      set_vec(7,  1'b0, 4'd15, 1'b1, 1'b1, 4'd3, 8'h33, 1'b1, 8'h33, "hold_wr3");
      set_vec(8,  1'b1, 4'd4,  1'b0, 1'b1, 4'd4, 8'hFF, 1'b1, 8'h22, "gate_ew0");
      set_vec(9,  1'b0, 4'd0,  1'b1, 1'b0, 4'd4, 8'hFF, 1'b1, 8'h22, "gate_we0");
      set_vec(10, 1'b0, 4'd0,  1'b1, 1'b1, 4'd4, 8'hFF, 1'b1, 8'hFF, "gate_both");
      set_vec(11, 1'b1, 4'd7,  1'b1, 1'b1, 4'd7, 8'hA5, 1'b1, 8'hA5, "collide7");
      set_vec(12, 1'b0, 4'd0,  1'b1, 1'b1, 4'd8, 8'h44, 1'b1, 8'hA5, "other_addr");

      // Reset sequence
      rst_n = 1'b0;
      cyc();
      cyc();
      rst_n = 1'b1;
      drive(1'b0, 4'd0, 1'b1, 1'b1, 4'd0, 8'h77);
      cyc();
      drive(1'b1, 4'd5, 1'b1, 1'b1, 4'd5, 8'h66);
      cyc();
      chk("pre_reset_read5", {56'd0, read_data}, 64'h66);
      drive(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 8'h00);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_reset_ra0", {56'd0, read_data}, 64'h77);
      drive(1'b0, 4'd0, 1'b1, 1'b1, 4'd0, 8'hEE);
      cyc();
      chk("write_in_reset", {56'd0, read_data}, 64'h77);
      rst_n = 1'b1;
      drive(1'b0, 4'd9, 1'b1, 1'b1, 4'd0, 8'h5A);
      cyc();
      chk("post_reset_wr0", {56'd0, read_data}, 64'h5A);

      // Table-driven vectors through the scoreboard
      for (int i = 0; i < 13; i++) begin
         drive(vecs[i].ren, vecs[i].raddr, vecs[i].ew, vecs[i].we, vecs[i].waddr,
               vecs[i].wdata);
         if (vecs[i].check)
            sb_q.push_back({56'd0, vecs[i].exp});
         cyc();
         if (vecs[i].check) begin
            if (sb_q.size() == 0)
               chk({vecs[i].name, "_sb_empty"}, 64'd1, 64'd0);
            else
               chk(vecs[i].name, {56'd0, read_data}, sb_q.pop_front());
         end
      end
      drive(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 8'h00);

      // Wide DTLB-shaped instance
      w_enable_write = 1'b1; w_write_enable = 1'b1;
      w_write_address = 10'd0; w_write_data = 44'hABC_DEF0_1234;
      cyc();
      w_write_address = 10'd1023; w_write_data = 44'h543_210F_EDCB;
      cyc();
      w_enable_write = 1'b0; w_write_enable = 1'b0;
      w_enable_read = 1'b1; w_read_address = 10'd1023;
      sb_q.push_back({20'd0, 44'h543_210F_EDCB});
      cyc();
      chk("wide_1023", {20'd0, w_read_data}, sb_q.pop_front());
      w_read_address = 10'd0;
      sb_q.push_back({20'd0, 44'hABC_DEF0_1234});
      cyc();
      chk("wide_0", {20'd0, w_read_data}, sb_q.pop_front());
      w_enable_read = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
